mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
- Sequencing controller for the shift-add multiplier datapath inside the MIPS CPU.
- Accepts MULT/MULTU requests from the EX stage and drives datapath Load/Ad/Sh/Neg strobes.
- Counts iterations internally, so the datapath needs no external k input.
- Handles signed correction, the HI/LO write-enable, pipeline abort and stall for MFHI/MFLO hazards.

Parameters:
- WIDTH, 32, operand width in bits; the iteration count equals WIDTH.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-high reset.
- Req  input  1  start request from EX; sampled only in IDLE.
- Signed_op  input  1  1 = MULT, 0 = MULTU; latched with Req.
- A_sign  input  1  multiplicand MSB, valid with Req.
- B_sign  input  1  multiplier MSB, valid with Req.
- M  input  1  current multiplier LSB from the datapath.
- Abort  input  1  pipeline flush; cancels any operation in progress.
- Rd_hilo  input  1  MFHI/MFLO in EX this cycle.
- Idle  output  1  sequencer is in IDLE.
- Busy  output  1  operation in flight: any state other than IDLE.
- Load  output  1  datapath loads operands (absolute values if Neg_in).
- Neg_in  output  1  with Load: datapath takes two's-complement of negative operands.
- Ad  output  1  datapath adds multiplicand into the upper accumulator.
- Sh  output  1  datapath shifts the accumulator right by 1.
- Neg_out  output  1  datapath negates the 2*WIDTH product.
- Hilo_we  output  1  write the product into HI/LO at this edge.
- Done  output  1  one-cycle completion pulse, coincident with Hilo_we.
- Stall  output  1  hold IF/ID/EX.

Behaviour:
- Reset (asynchronous): state = IDLE, counter = 0, sign flag = 0. Idle = 1; all other outputs = 0.
- Outputs are Moore-decoded from state, except Ad (state ADD & M) and Stall (Rd_hilo & Busy).
- States and transitions:
  - IDLE: on Req go to LOAD and latch neg = Signed_op & (A_sign ^ B_sign); otherwise stay.
  - LOAD: Load = 1; Neg_in = latched Signed_op; counter cleared to 0; go to ADD.
  - ADD: Ad = M; go to SHIFT.
  - SHIFT: Sh = 1; counter increments. If the counter reaches WIDTH-1 before the increment, go to FIX when neg = 1, else to DONE. Otherwise return to ADD.
  - FIX: Neg_out = 1; go to DONE.
  - DONE: Hilo_we = 1, Done = 1; go to IDLE.
- Latency from the Req edge to the Done cycle: 1 + 2*WIDTH + (neg ? 1 : 0) cycles. For WIDTH = 32 this is 65 cycles unsigned, 66 with sign fix.
- Req outside IDLE is ignored; no queueing.
- Req in the cycle after DONE, i.e. in IDLE, is accepted normally. Back-to-back throughput is therefore one operation per latency + 1 cycles.
- Abort has priority over every transition. Next state = IDLE, no Hilo_we, counter cleared. Abort in DONE still lets that cycle's Hilo_we commit (the write is already at this edge). Abort in IDLE is a no-op. Abort together with Req in IDLE: Abort wins, the request is dropped.
- Stall = Rd_hilo & Busy, including in DONE, because HI/LO update at the end of DONE. Stall = 0 while Idle.
- Reset mid-operation: immediate return to IDLE with all strobes deasserted. HI/LO are not written.
- Signed_op, A_sign and B_sign are don't-care outside the Req cycle in IDLE.
- Counter never exceeds WIDTH-1 and never wraps: it is cleared in LOAD.

Decomposition:
- Shared package mul_pkg holds:
  - state encoding: IDLE = 0, LOAD, ADD, SHIFT, FIX, DONE (3 bits);
  - strobe index constants for Load, Ad, Sh, Neg_in, Neg_out, Hilo_we;
  - default WIDTH.
- One sub-module, mul_iter_counter: clear / increment / terminal-count output, parameterised by WIDTH and CNT_W.
- FSM and output decode remain in mul_sequencer.

Test Plan:
- WIDTH=4, Req with Signed_op=0, M pattern 1,0,1,1 -> Load at cycle 1; Ad in ADD cycles 1,3,4 only; 4 Sh pulses; Done/Hilo_we at cycle 10; Idle at 11.
- WIDTH=32, MULT with A_sign=1, B_sign=0 -> Neg_in with Load; Neg_out one cycle before Done; Done 66 cycles after Req. Same operands as MULTU -> no Neg_in/Neg_out; Done after 65 cycles.
- Abort on the 3rd SHIFT -> IDLE next cycle; Hilo_we never asserts. A following Req restarts cleanly with a full count.
- Req pulsed in every cycle during an operation -> only the first is accepted; a Req in the cycle after Done starts a second operation.
- Rd_hilo held high from Req through completion -> Stall = 1 through DONE inclusive, 0 in the first IDLE cycle.
- Rst asserted asynchronously mid-ADD with Ad = 1 -> all strobes drop without a clock edge; Idle = 1; no Hilo_we after release.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the shift-add multiplier sequencer: state encoding,
// strobe bit positions and default operand width.
package mul_pkg;

    localparam int unsigned DefaultWidth = 32;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StAdd   = 3'd2,
        StShift = 3'd3,
        StFix   = 3'd4,
        StDone  = 3'd5
    } state_e;

    localparam int unsigned StbLoad   = 0;
    localparam int unsigned StbAd     = 1;
    localparam int unsigned StbSh     = 2;
    localparam int unsigned StbNegIn  = 3;
    localparam int unsigned StbNegOut = 4;
    localparam int unsigned StbHiloWe = 5;
    localparam int unsigned NumStb    = 6;

    typedef logic [NumStb-1:0] strobe_t;

endpackage

// File: rtl/mul_iter_counter.sv
// Iteration counter for the multiplier: synchronous clear, saturating increment
// and a terminal-count flag raised when the count equals WIDTH-1.
module mul_iter_counter
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CNT_W = 6
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] Last = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != Last)) begin
            // Saturate at WIDTH-1: the final SHIFT must not push the count past it.
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == Last);

endmodule

// File: rtl/mul_sequencer.sv
// MULT/MULTU sequencing controller for the shift-add multiplier datapath:
// load, WIDTH add/shift pairs, optional sign fix, then HI/LO write.
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CNT_W = 6
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic signed_op_i,
    input  logic a_sign_i,
    input  logic b_sign_i,
    input  logic m_i,
    input  logic abort_i,
    input  logic rd_hilo_i,
    output logic idle_o,
    output logic busy_o,
    output logic load_o,
    output logic neg_in_o,
    output logic ad_o,
    output logic sh_o,
    output logic neg_out_o,
    output logic hilo_we_o,
    output logic done_o,
    output logic stall_o
);

    state_e  state_q, state_d;
    logic    neg_q, neg_d;
    logic    sgn_q, sgn_d;
    strobe_t stb;
    logic    cnt_clr, cnt_inc, cnt_tc;

    mul_iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .tc_o  (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        neg_d   = neg_q;
        sgn_d   = sgn_q;
        stb     = '0;
        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    state_d = StLoad;
                    neg_d   = signed_op_i & (a_sign_i ^ b_sign_i);
                    sgn_d   = signed_op_i;
                end
            end
            StLoad: begin
                stb[StbLoad]  = 1'b1;
                stb[StbNegIn] = sgn_q;
                state_d       = StAdd;
            end
            StAdd: begin
                stb[StbAd] = m_i;
                state_d    = StShift;
            end
            StShift: begin
                stb[StbSh] = 1'b1;
                if (cnt_tc) begin
                    state_d = neg_q ? StFix : StDone;
                end else begin
                    state_d = StAdd;
                end
            end
            StFix: begin
                stb[StbNegOut] = 1'b1;
                state_d        = StDone;
            end
            StDone: begin
                stb[StbHiloWe] = 1'b1;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Abort overrides every transition; a DONE-cycle write still commits.
        if (abort_i) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            neg_q   <= 1'b0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            neg_q   <= neg_d;
            sgn_q   <= sgn_d;
        end
    end

    assign cnt_clr = (state_q == StLoad) | abort_i;
    assign cnt_inc = (state_q == StShift);

    assign idle_o    = (state_q == StIdle);
    assign busy_o    = ~idle_o;
    assign load_o    = stb[StbLoad];
    assign neg_in_o  = stb[StbNegIn];
    assign ad_o      = stb[StbAd];
    assign sh_o      = stb[StbSh];
    assign neg_out_o = stb[StbNegOut];
    assign hilo_we_o = stb[StbHiloWe];
    assign done_o    = stb[StbHiloWe];
    assign stall_o   = rd_hilo_i & busy_o;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench: WIDTH=4 and WIDTH=32 sequencers driven in parallel and
// compared each cycle with a phase-index reference model.
module tb_mul_sequencer;

    logic clk = 1'b0;
    logic rst, req, signed_op, a_sign, b_sign, m, abort, rd_hilo;
    logic [1:0] idle, busy, load, neg_in, ad, sh, neg_out, hilo_we, done, stall;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: ph = -1 when idle, else index of the cycle since Load.
    int wid[2] = '{4, 32};
    int ph[2];
    bit mneg[2];
    bit msgn[2];

    int sc;
    int done_at[2];
    int ad_cnt[2];
    int sh_cnt[2];
    int negout_at[2];

    mul_sequencer #(.WIDTH(4), .CNT_W(3)) u_dut4 (
        .clk_i (clk), .rst_i (rst), .req_i (req), .signed_op_i (signed_op),
        .a_sign_i (a_sign), .b_sign_i (b_sign), .m_i (m), .abort_i (abort),
        .rd_hilo_i (rd_hilo), .idle_o (idle[0]), .busy_o (busy[0]), .load_o (load[0]),
        .neg_in_o (neg_in[0]), .ad_o (ad[0]), .sh_o (sh[0]), .neg_out_o (neg_out[0]),
        .hilo_we_o (hilo_we[0]), .done_o (done[0]), .stall_o (stall[0])
    );

    mul_sequencer #(.WIDTH(32), .CNT_W(6)) u_dut32 (
        .clk_i (clk), .rst_i (rst), .req_i (req), .signed_op_i (signed_op),
        .a_sign_i (a_sign), .b_sign_i (b_sign), .m_i (m), .abort_i (abort),
        .rd_hilo_i (rd_hilo), .idle_o (idle[1]), .busy_o (busy[1]), .load_o (load[1]),
        .neg_in_o (neg_in[1]), .ad_o (ad[1]), .sh_o (sh[1]), .neg_out_o (neg_out[1]),
        .hilo_we_o (hilo_we[1]), .done_o (done[1]), .stall_o (stall[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int last_phase(input int i);
        return 2 * wid[i] + 1 + (mneg[i] ? 1 : 0);
    endfunction

    // Bit order: {stall, done, hilo_we, neg_out, sh, ad, neg_in, load, busy, idle}
    function automatic logic [9:0] expect_out(input int i);
        int p;
        int w;
        logic run;
        p   = ph[i];
        w   = wid[i];
        run = (p >= 1) && (p <= 2 * w);
        return {rd_hilo && (p >= 0),
                p == last_phase(i),
                p == last_phase(i),
                mneg[i] && (p == 2 * w + 1),
                run && (p % 2 == 0),
                run && (p % 2 == 1) && m,
                (p == 0) && msgn[i],
                p == 0,
                p >= 0,
                p < 0};
    endfunction

    function automatic logic [9:0] actual_out(input int i);
        return {stall[i], done[i], hilo_we[i], neg_out[i], sh[i], ad[i],
                neg_in[i], load[i], busy[i], idle[i]};
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (abort) begin
                ph[i] = -1;
            end else if (ph[i] < 0) begin
                if (req) begin
                    ph[i]   = 0;
                    mneg[i] = signed_op & (a_sign ^ b_sign);
                    msgn[i] = signed_op;
                end
            end else if (ph[i] == last_phase(i)) begin
                ph[i] = -1;
            end else begin
                ph[i]++;
            end
        end
    endtask

    task automatic clear_stats();
        sc = 0;
        for (int i = 0; i < 2; i++) begin
            done_at[i]   = -1;
            negout_at[i] = -1;
            ad_cnt[i]    = 0;
            sh_cnt[i]    = 0;
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("w%0d outputs", wid[i]), 32'(actual_out(i)), 32'(expect_out(i)));
            if (done[i] && done_at[i] < 0) done_at[i] = sc;
            if (neg_out[i] && negout_at[i] < 0) negout_at[i] = sc;
            ad_cnt[i] += int'(ad[i]);
            sh_cnt[i] += int'(sh[i]);
        end
        sc++;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic quiet();
        req = 1'b0; abort = 1'b0; rd_hilo = 1'b0; m = 1'b0;
    endtask

    task automatic drain();
        quiet();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic latency_run(input logic sg, input logic as, input logic bs, input int i,
                               input string tag);
        drain();
        clear_stats();
        req = 1'b1; signed_op = sg; a_sign = as; b_sign = bs;
        step();
        req = 1'b0;
        for (int k = 0; k < 200 && done_at[i] < 0; k++) begin
            m = 1'($urandom);
            step();
        end
        check({tag, " latency"}, 32'(done_at[i] - 1),
              32'(1 + 2 * wid[i] + ((sg && (as ^ bs)) ? 1 : 0)));
        check({tag, " neg_out pos"}, 32'(negout_at[i]),
              (sg && (as ^ bs)) ? 32'(done_at[i] - 1) : 32'hffff_ffff);
    endtask

    initial begin
        logic [3:0] pat;
        pat = 4'b1101;  // M for ADD iterations 1..4 is pat[0..3] = 1,0,1,1
        for (int i = 0; i < 2; i++) begin
            ph[i] = -1; mneg[i] = 1'b0; msgn[i] = 1'b0;
        end
        rst = 1'b1; signed_op = 1'b0; a_sign = 1'b0; b_sign = 1'b0;
        quiet();
        #1;
        for (int i = 0; i < 2; i++) check("reset outputs", 32'(actual_out(i)), 32'h1);
        @(negedge clk);
        rst = 1'b0;

        // WIDTH=4 unsigned with fixed M pattern.
        clear_stats();
        req = 1'b1; signed_op = 1'b0;
        step();
        req = 1'b0;
        for (int k = 0; k < 30 && done_at[0] < 0; k++) begin
            m = (ph[0] >= 1 && ph[0] % 2 == 1) ? pat[(ph[0] - 1) / 2] : 1'b0;
            step();
        end
        check("w4 done cycle", 32'(done_at[0]), 32'd10);
        check("w4 ad pulses", 32'(ad_cnt[0]), 32'd3);
        check("w4 sh pulses", 32'(sh_cnt[0]), 32'd4);
        step();
        check("w4 idle after done", 32'(idle[0]), 32'd1);

        latency_run(1'b1, 1'b1, 1'b0, 1, "w32 mult");
        latency_run(1'b0, 1'b1, 1'b0, 1, "w32 multu");

        // Abort on the third SHIFT of a WIDTH=4 op, then restart.
        drain();
        clear_stats();
        req = 1'b1; signed_op = 1'b0;
        step();
        req = 1'b0;
        for (int k = 0; k < 20 && ph[0] != 6; k++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("w4 idle after abort", 32'(idle[0]), 32'd1);
        clear_stats();
        req = 1'b1;
        step();
        req = 1'b0;
        for (int k = 0; k < 30 && done_at[0] < 0; k++) step();
        check("w4 restart done", 32'(done_at[0]), 32'd10);

        // Req held high; Rd_hilo held high for stall coverage.
        drain();
        req = 1'b1; rd_hilo = 1'b1;
        for (int k = 0; k < 200; k++) begin
            signed_op = 1'($urandom); a_sign = 1'($urandom); b_sign = 1'($urandom);
            m = 1'($urandom);
            step();
        end

        // Asynchronous reset during a WIDTH=32 ADD with M=1.
        drain();
        req = 1'b1; signed_op = 1'b0;
        step();
        req = 1'b0;
        for (int k = 0; k < 10 && ph[1] != 3; k++) step();
        m = 1'b1;
        #1;
        check("w32 ad before rst", 32'(ad[1]), 32'd1);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("async rst outputs", 32'(actual_out(i)), 32'h1);
            ph[i] = -1;
        end
        @(negedge clk);
        rst = 1'b0;
        quiet();
        for (int k = 0; k < 5; k++) step();

        // Randomized traffic.
        for (int k = 0; k < 4000; k++) begin
            req       = ($urandom_range(0, 3) == 0);
            signed_op = 1'($urandom);
            a_sign    = 1'($urandom);
            b_sign    = 1'($urandom);
            m         = 1'($urandom);
            rd_hilo   = 1'($urandom);
            abort     = ($urandom_range(0, 149) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
